// File: rtl/vedic_seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Ports: clk, rst_n, start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero.
module vedic_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t           r_state, w_state;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [WIDTH-1:0] r_div, w_div;
  logic [WIDTH:0]   r_rem, w_rem;
  logic [WIDTH-1:0] r_q, w_q;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic [WIDTH-1:0] r_quo, w_quo;
  logic [WIDTH-1:0] r_rmd, w_rmd;
  logic             r_dbz, w_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_nrem;
  logic [WIDTH-1:0] w_nq;
  logic             w_qbit;

  // Subtract as an adder: shifted + ~{0,divisor} + 1.
  // The MSB of the result clear means the trial subtraction fit.
  assign w_shift = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_diff  = w_shift + {1'b1, ~r_div}
                 + (WIDTH+1)'(1);
  assign w_qbit  = ~w_diff[WIDTH];
  assign w_nrem  = w_qbit ? w_diff : w_shift;
  assign w_nq    = {r_q[WIDTH-2:0], w_qbit};

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_div   = r_div;
    w_rem   = r_rem;
    w_q     = r_q;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_quo   = r_quo;
    w_rmd   = r_rmd;
    w_dbz   = r_dbz;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            w_done = 1'b1;
            w_dbz  = 1'b1;
            w_quo  = '1;
            w_rmd  = dividend;
          end else begin
            w_div   = divisor;
            w_rem   = '0;
            w_q     = dividend;
            w_cnt   = CW'(WIDTH);
            w_busy  = 1'b1;
            w_dbz   = 1'b0;
            w_state = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_rem = w_nrem;
        w_q   = w_nq;
        w_cnt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_quo   = w_nq;
          w_rmd   = w_nrem[WIDTH-1:0];
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_div   <= w_div;
      r_rem   <= w_rem;
      r_q     <= w_q;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_quo   <= w_quo;
      r_rmd   <= w_rmd;
      r_dbz   <= w_dbz;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quo;
  assign remainder   = r_rmd;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_vedic_seq_divider.sv
// Bench for vedic_seq_divider: vector table, random ops vs.
// an arithmetic model, and hand-written handshake/reset sequences.
module tb_vedic_seq_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  vedic_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d",
               nm, act, exp);
    end
  endtask

  function automatic void model(
    input  logic [W-1:0] dd,
    input  logic [W-1:0] dv,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         z);
    if (dv == 0) begin
      q = '1;
      r = dd;
      z = 1'b1;
    end else begin
      q = dd / dv;
      r = dd % dv;
      z = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm,
                        input logic [W-1:0] dd,
                        input logic [W-1:0] dv);
    logic [W-1:0] eq, er;
    logic         ez;
    int           k;
    int           lat;
    logic         busy_ok;
    model(dd, dv, eq, er, ez);
    lat      = (dv == 0) ? 0 : W;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    k        = 0;
    busy_ok  = 1'b1;
    while (!done && k < W + 4) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      k++;
    end
    check({nm, " done"}, done, 1);
    check({nm, " lat"}, k, lat);
    check({nm, " busy"}, busy_ok, 1);
    check({nm, " busy@done"}, busy, 0);
    check({nm, " q"}, quotient, eq);
    check({nm, " r"}, remainder, er);
    check({nm, " dbz"}, div_by_zero, ez);
    if (!ez) begin
      check({nm, " inv"},
            32'(quotient) * 32'(dv) + 32'(remainder),
            32'(dd));
      check({nm, " r<d"}, remainder < dv, 1);
    end
    tick();
    check({nm, " pulse"}, done, 0);
  endtask

  initial begin
    int           k;
    int           ndone;
    logic [W-1:0] cq, cr;
    logic         flag;

    tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    tbl[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    tbl[4] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0};
    tbl[5] = '{8'd13,  8'd0,   8'd255, 8'd13, 1'b1};
    tbl[6] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) tick();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst q", quotient, 0);
    check("rst r", remainder, 0);
    check("rst dbz", div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("tbl%0d", i),
             tbl[i].dd, tbl[i].dv);
      check($sformatf("tbl%0d tq", i),
            quotient, tbl[i].q);
      check($sformatf("tbl%0d tr", i),
            remainder, tbl[i].r);
      check($sformatf("tbl%0d tz", i),
            div_by_zero, tbl[i].z);
    end

    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] rd, rv;
      rd = W'($urandom);
      rv = ($urandom_range(0, 7) == 0)
           ? '0 : W'($urandom);
      run_op($sformatf("rnd%0d", i), rd, rv);
    end

    // start while busy must be ignored
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    ndone    = 0;
    cq       = '0;
    cr       = '0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) begin
        ndone++;
        cq = quotient;
        cr = remainder;
      end
      tick();
    end
    check("ign ndone", ndone, 1);
    check("ign q", cq, 14);
    check("ign r", cr, 2);

    // back-to-back with start held high
    dividend = 8'd200;
    divisor  = 8'd9;
    start    = 1'b1;
    tick();
    k = 0;
    while (!done && k < W + 4) begin
      tick();
      k++;
    end
    check("b2b1 done", done, 1);
    check("b2b1 lat", k, W);
    check("b2b1 q", quotient, 22);
    check("b2b1 r", remainder, 2);
    dividend = 8'd77;
    divisor  = 8'd4;
    tick();
    check("b2b2 busy", busy, 1);
    check("b2b2 done", done, 0);
    k    = 0;
    flag = 1'b1;
    while (!done && k < W + 4) begin
      if (quotient !== 8'd22) flag = 1'b0;
      if (remainder !== 8'd2) flag = 1'b0;
      tick();
      k++;
    end
    start = 1'b0;
    check("b2b hold", flag, 1);
    check("b2b2 lat", k, W);
    check("b2b2 q", quotient, 19);
    check("b2b2 r", remainder, 1);
    tick();

    // async reset in the middle of CALC
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    check("arst q", quotient, 0);
    check("arst r", remainder, 0);
    check("arst dbz", div_by_zero, 0);
    flag = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (done !== 1'b0) flag = 1'b0;
    end
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (done !== 1'b0) flag = 1'b0;
    end
    check("arst nodone", flag, 1);
    run_op("post-rst", 8'd100, 8'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
